// File: rtl/stim_gen_tracker.sv
// Burst traffic source on a valid/ready channel with incrementing or LFSR data,
// plus backpressure tracking (accepted words, total stall, worst per-word stall).
module stim_gen_tracker #(
    parameter int unsigned DW      = 16,
    parameter int unsigned NUM_TXN = 8,
    parameter int unsigned GAP     = 2,
    parameter logic [15:0] SEED    = 16'h0001,
    parameter int unsigned MODE    = 0,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          dn_valid,
    output logic [DW-1:0] dn_data,
    input  logic          dn_ready,
    output logic          done,
    output logic [CW-1:0] txn_cnt,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] max_stall
);

    localparam int unsigned SW = $clog2(NUM_TXN + 1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DW-1:0] SEED_W  = DW'(SEED);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [SW-1:0] LAST    = SW'(NUM_TXN - 1);
    localparam logic [GW-1:0] GAP_LD  = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] txn_q, txn_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [CW-1:0] max_q, max_d;
    logic [CW-1:0] cur_q, cur_d;
    logic [SW-1:0] sent_q, sent_d;
    logic [GW-1:0] gap_q, gap_d;

    function automatic logic [DW-1:0] next_word(input logic [DW-1:0] d);
        logic [15:0] w;
        w = 16'(d);
        if (MODE == 1) return DW'({w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]});
        else           return d + DW'(1);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        done_d  = done_q;
        data_d  = data_q;
        txn_d   = txn_q;
        stall_d = stall_q;
        max_d   = max_q;
        cur_d   = cur_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SEND;
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                    data_d  = SEED_W;
                    txn_d   = '0;
                    stall_d = '0;
                    max_d   = '0;
                    cur_d   = '0;
                    sent_d  = '0;
                end
            end
            S_SEND: begin
                if (dn_ready) begin
                    txn_d  = sat_inc(txn_q);
                    max_d  = (cur_q > max_q) ? cur_q : max_q;
                    cur_d  = '0;
                    data_d = next_word(data_q);
                    if (sent_q == LAST) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        sent_d  = '0;
                    end else begin
                        sent_d = sent_q + SW'(1);
                        if (GAP != 0) begin
                            state_d = S_GAP;
                            valid_d = 1'b0;
                            gap_d   = GAP_LD;
                        end
                    end
                end else begin
                    stall_d = sat_inc(stall_q);
                    cur_d   = sat_inc(cur_q);
                end
            end
            S_GAP: begin
                // dn_ready is deliberately ignored while the gap runs down
                if (gap_q == '0) begin
                    state_d = S_SEND;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= SEED_W;
            txn_q   <= '0;
            stall_q <= '0;
            max_q   <= '0;
            cur_q   <= '0;
            sent_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            data_q  <= data_d;
            txn_q   <= txn_d;
            stall_q <= stall_d;
            max_q   <= max_d;
            cur_q   <= cur_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
        end
    end

    assign dn_valid  = valid_q;
    assign dn_data   = data_q;
    assign done      = done_q;
    assign txn_cnt   = txn_q;
    assign stall_cnt = stall_q;
    assign max_stall = max_q;

endmodule
